// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes unit. It accepts a 128-bit state over a valid/ready handshake and
// substitutes LANES bytes per clock through replicated inverse S-box ROMs. It returns the result
// over a second valid/ready handshake.
module inv_sub_bytes_seq #(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int unsigned STEPS  = 16 / LANES;
  localparam int unsigned STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  // Inverse S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Top bit of entry b sits at 2047 - 8*b, which is {~b, 3'b111}.
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TBL[{~b, 3'b111} -: 8];
  endfunction

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e              r_state;
  logic [STEP_W-1:0]   r_step;
  logic [127:0]        r_work;
  logic                r_busy;
  logic                r_out_valid;

  logic [7:0]          w_sub [LANES];
  logic [127:0]        w_work_nxt;
  logic                w_last;

  // One ROM per lane; each lane looks at its byte within the current step's window.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0] w_lane_in;
    assign w_lane_in = r_work[8 * (int'(r_step) * LANES + l) +: 8];
    assign w_sub[l]  = inv_sbox(w_lane_in);
  end

  // Working register with the current window of bytes replaced by their substitutions.
  always_comb begin
    w_work_nxt = r_work;
    for (int l = 0; l < LANES; l++) begin
      w_work_nxt[8 * (int'(r_step) * LANES + l) +: 8] = w_sub[l];
    end
  end

  assign w_last = (r_step == LAST_STEP);

  // Control FSM with registered busy/out_valid; DONE can reload on the same edge it hands off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_step      <= '0;
      r_work      <= '0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_work  <= in_state;
            r_step  <= '0;
            r_busy  <= 1'b1;
            r_state <= StBusy;
          end
        end
        StBusy: begin
          r_work <= w_work_nxt;
          if (w_last) begin
            r_step      <= '0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= StDone;
          end else begin
            r_step <= r_step + STEP_W'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (in_valid) begin
              r_work  <= in_state;
              r_step  <= '0;
              r_busy  <= 1'b1;
              r_state <= StBusy;
            end else begin
              r_state <= StIdle;
            end
          end
        end
        default: begin
          r_state     <= StIdle;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // In DONE, readiness follows the consumer so a new block can load as the result leaves.
  assign in_ready  = (r_state == StIdle) | ((r_state == StDone) & out_ready);
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign out_state = r_work;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Self-checking bench for inv_sub_bytes_seq: a vector table, corner-case sequences and a
// randomized run scored against an S-box derived from GF(2^8) arithmetic.
module tb_inv_sub_bytes_seq;

  localparam int NAUX  = 4;
  localparam int NRAND = 1000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_state, out_state;

  logic         aux_in_valid  [NAUX];
  logic         aux_in_ready  [NAUX];
  logic         aux_out_valid [NAUX];
  logic         aux_out_ready [NAUX];
  logic         aux_busy      [NAUX];
  logic [127:0] aux_in_state  [NAUX];
  logic [127:0] aux_out_state [NAUX];

  int checks = 0;
  int errors = 0;

  logic [7:0] fwd_tbl [256];
  logic [7:0] inv_tbl [256];

  typedef struct {
    logic [127:0] st;
    logic [127:0] exp;
  } vec_t;
  vec_t vecs [6];

  logic [127:0] exp_q [$];

  always #5 clk = ~clk;

  inv_sub_bytes_seq #(.LANES(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  // Extra instances with LANES = 1, 2, 8, 16.
  for (genvar g = 0; g < NAUX; g++) begin : g_aux
    localparam int unsigned L = (g < 2) ? (1 << g) : (1 << (g + 1));
    inv_sub_bytes_seq #(.LANES(L)) u_aux (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (aux_in_valid[g]),
      .in_ready  (aux_in_ready[g]),
      .in_state  (aux_in_state[g]),
      .out_valid (aux_out_valid[g]),
      .out_ready (aux_out_ready[g]),
      .out_state (aux_out_state[g]),
      .busy      (aux_busy[g])
    );
  end

  function automatic int aux_steps(input int g);
    int l;
    l = (g < 2) ? (1 << g) : (1 << (g + 1));
    return 16 / l;
  endfunction

  // GF(2^8) reference: multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    if (a == 8'h00) return 8'h00;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] model_inv(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = inv_tbl[s[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] model_fwd(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = fwd_tbl[s[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Present st on the main DUT until accepted; returns #1 after the handshake edge.
  task automatic send_main(input logic [127:0] st);
    logic rdy;
    in_valid = 1'b1;
    in_state = st;
    for (int c = 0; c < 100; c++) begin
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    checks++; errors++;
    $display("FAIL send_main: in_ready never seen within 100 cycles");
  endtask

  // Cycles from the handshake edge until out_valid, and how many of them had busy high.
  task automatic wait_out(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (!out_valid && lat < 100) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic pop_main();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic aux_run(input int g, input logic [127:0] st, input logic [127:0] exp);
    int lat;
    chk("aux in_ready idle", aux_in_ready[g], 1'b1);
    aux_in_valid[g] = 1'b1;
    aux_in_state[g] = st;
    @(posedge clk); #1;
    aux_in_valid[g] = 1'b0;
    lat = 0;
    while (!aux_out_valid[g] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("aux%0d latency", g), 128'(lat), 128'(aux_steps(g)));
    chk($sformatf("aux%0d out_state", g), aux_out_state[g], exp);
    aux_out_ready[g] = 1'b1;
    @(posedge clk); #1;
    aux_out_ready[g] = 1'b0;
    chk($sformatf("aux%0d out_valid drop", g), aux_out_valid[g], 1'b0);
  endtask

  initial begin
    int           lat, bcnt;
    logic         stable;
    logic [127:0] a, b, snap;

    in_valid = 1'b0; out_ready = 1'b0; in_state = '0;
    for (int g = 0; g < NAUX; g++) begin
      aux_in_valid[g] = 1'b0; aux_out_ready[g] = 1'b0; aux_in_state[g] = '0;
    end

    for (int x = 0; x < 256; x++) fwd_tbl[x] = sbox_fwd(8'(x));
    for (int x = 0; x < 256; x++) inv_tbl[fwd_tbl[x]] = 8'(x);

    vecs[0] = '{st: {16{8'h63}}, exp: 128'h0};
    vecs[1] = '{st: 128'h0, exp: {16{8'h52}}};
    vecs[2] = '{st: model_fwd(128'h0f0e0d0c0b0a09080706050403020100),
                exp: 128'h0f0e0d0c0b0a09080706050403020100};
    vecs[3] = '{st: {16{8'hff}}, exp: {16{8'h7d}}};
    vecs[4] = '{st: {16{8'hed}}, exp: {16{8'h53}}};
    vecs[5] = '{st: {4{32'h637c00ff}}, exp: {4{32'h0001527d}}};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset in_ready", in_ready, 1'b1);
    chk("reset busy", busy, 1'b0);
    chk("reset out_state", out_state, 128'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table vectors on the LANES=4 instance: value, latency, busy duration, return to idle
    foreach (vecs[i]) begin
      send_main(vecs[i].st);
      wait_out(lat, bcnt);
      chk($sformatf("vec%0d latency", i), 128'(lat), 128'd4);
      chk($sformatf("vec%0d busy cycles", i), 128'(bcnt), 128'd4);
      chk($sformatf("vec%0d out_state", i), out_state, vecs[i].exp);
      pop_main();
      chk($sformatf("vec%0d out_valid drop", i), out_valid, 1'b0);
      chk($sformatf("vec%0d in_ready idle", i), in_ready, 1'b1);
    end

    // Other lane counts: latency STEPS and round-trip recovery
    for (int g = 0; g < NAUX; g++) begin
      aux_run(g, vecs[0].st, vecs[0].exp);
      aux_run(g, vecs[2].st, vecs[2].exp);
    end

    // Backpressure in DONE, then same-edge hand-off and reload
    a = rand128();
    b = rand128();
    send_main(a);
    wait_out(lat, bcnt);
    snap = out_state;
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (!out_valid || out_state !== snap || in_ready) stable = 1'b0;
    end
    chk("bp hold stable", stable, 1'b1);
    chk("bp held value", snap, model_inv(a));
    in_valid = 1'b1;
    in_state = b;
    out_ready = 1'b1;
    #1;
    chk("bp in_ready passthru", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("bp reload busy", busy, 1'b1);
    chk("bp reload out_valid", out_valid, 1'b0);
    wait_out(lat, bcnt);
    chk("bp second latency", 128'(lat), 128'd4);
    chk("bp second value", out_state, model_inv(b));
    pop_main();

    // in_valid during BUSY must be ignored
    a = rand128();
    send_main(a);
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_state = rand128();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_out(lat, bcnt);
    chk("busy-ignore value", out_state, model_inv(a));
    pop_main();
    repeat (3) @(posedge clk);
    #1;
    chk("busy-ignore no extra block", {busy, out_valid}, 2'b00);

    // Asynchronous reset at step 2 discards the block
    a = rand128();
    send_main(a);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    chk("mid reset out_valid", out_valid, 1'b0);
    chk("mid reset in_ready", in_ready, 1'b1);
    chk("mid reset out_state", out_state, 128'h0);
    chk("mid reset busy", busy, 1'b0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    b = rand128();
    send_main(b);
    wait_out(lat, bcnt);
    chk("post reset latency", 128'(lat), 128'd4);
    chk("post reset value", out_state, model_inv(b));
    pop_main();

    // Randomized stream with gaps and backpressure, scored in order
    exp_q.delete();
    fork
      begin : drv
        logic [127:0] st;
        logic         rdy;
        logic         hs;
        int           gap;
        @(posedge clk); #2;
        for (int i = 0; i < NRAND; i++) begin
          gap = $urandom_range(0, 2);
          in_valid = 1'b0;
          repeat (gap) begin
            @(posedge clk); #2;
          end
          st = rand128();
          in_valid = 1'b1;
          in_state = st;
          hs = 1'b0;
          for (int c = 0; c < 200 && !hs; c++) begin
            #1 rdy = in_ready;
            @(posedge clk); #2;
            if (rdy) begin
              hs = 1'b1;
              exp_q.push_back(model_inv(st));
            end
          end
          if (!hs) begin
            checks++; errors++;
            $display("FAIL rand accept: item %0d not accepted within 200 cycles", i);
          end
        end
        in_valid = 1'b0;
      end
      begin : mon
        int           rcv;
        int           cyc;
        logic [127:0] e;
        rcv = 0; cyc = 0;
        @(posedge clk);
        while (rcv < NRAND && cyc < 40000) begin
          #1 out_ready = ($urandom_range(0, 3) != 0);
          #2;
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL rand unexpected output: got %h expected none", out_state);
            end else begin
              e = exp_q.pop_front();
              chk("rand out_state", out_state, e);
            end
            rcv++;
          end
          @(posedge clk);
          cyc++;
        end
        chk("rand received count", 128'(rcv), 128'(NRAND));
      end
    join
    out_ready = 1'b1;
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (out_valid) stable = 1'b0;
    end
    out_ready = 1'b0;
    chk("rand no duplicate outputs", stable, 1'b1);
    chk("rand scoreboard drained", 128'(exp_q.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
